// File: rtl/hamming_pkg.sv
// Shared constants, state encoding and field helpers for the Hamming(7,4) link.
package hamming_pkg;
    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    localparam int P0_IDX = 0;
    localparam int P1_IDX = 1;
    localparam int P2_IDX = 3;

    localparam int D0_IDX = 2;
    localparam int D1_IDX = 4;
    localparam int D2_IDX = 5;
    localparam int D3_IDX = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        return {cw[D3_IDX], cw[D2_IDX], cw[D1_IDX], cw[D0_IDX]};
    endfunction
endpackage

// File: rtl/hamming74_correct.sv
// Combinational Hamming(7,4) single-error corrector: codeword in, corrected codeword and syndrome out.
module hamming74_correct
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  cw,
    output logic [CW_W-1:0]  corrected,
    output logic [SYN_W-1:0] syndrome
);
    logic [SYN_W-1:0] syn;

    always_comb begin
        syn[0] = cw[P0_IDX] ^ cw[D0_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX];
        syn[1] = cw[P1_IDX] ^ cw[D0_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        syn[2] = cw[P2_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        corrected = cw;
        // Syndrome value names the 1-based Hamming position of the bad bit.
        for (int i = 0; i < CW_W; i++) begin
            if (syn == SYN_W'(i + 1)) begin
                corrected[i] = ~cw[i];
            end
        end
        syndrome = syn;
    end
endmodule

// File: rtl/hamming_rx_deser.sv
// Serial Hamming(7,4) receiver: MSB-first deserializer, SEC decode, valid/ready output, saturating counters.
module hamming_rx_deser
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sdi_valid,
    input  logic              sdi,
    input  logic              sdi_sof,
    output logic              sdi_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome,
    output logic              err_corrected,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              frame_err
);
    state_t           state, state_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [CW_W-1:0]  sreg, sreg_nxt;
    logic             frame_err_nxt;
    logic             load_out;
    logic             handshake;
    logic [CW_W-1:0]  corr_cw;
    logic [SYN_W-1:0] corr_syn;

    hamming74_correct u_correct (
        .cw        (sreg),
        .corrected (corr_cw),
        .syndrome  (corr_syn)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        sreg_nxt      = sreg;
        frame_err_nxt = frame_err;
        load_out      = 1'b0;
        handshake     = 1'b0;
        case (state)
            IDLE: begin
                if (sdi_valid) begin
                    if (sdi_sof) begin
                        sreg_nxt    = {{(CW_W-1){1'b0}}, sdi};
                        bit_cnt_nxt = 3'd1;
                        state_nxt   = SHIFT;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (sdi_valid) begin
                    if (sdi_sof) begin
                        // Restart on a fresh frame; the partial word is dropped.
                        sreg_nxt      = {{(CW_W-1){1'b0}}, sdi};
                        bit_cnt_nxt   = 3'd1;
                        frame_err_nxt = 1'b1;
                    end else begin
                        sreg_nxt = {sreg[CW_W-2:0], sdi};
                        if (bit_cnt == 3'd6) begin
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = DECODE;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
            end
            DECODE: begin
                load_out  = 1'b1;
                state_nxt = HOLD;
                if (sdi_valid) frame_err_nxt = 1'b1;
            end
            HOLD: begin
                if (sdi_valid) frame_err_nxt = 1'b1;
                if (out_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt       <= '0;
            sreg          <= '0;
            frame_err     <= 1'b0;
            sdi_ready     <= 1'b1;
            out_valid     <= 1'b0;
            data_out      <= '0;
            syndrome      <= '0;
            err_corrected <= 1'b0;
            word_cnt      <= '0;
            err_cnt       <= '0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            sreg      <= sreg_nxt;
            frame_err <= frame_err_nxt;
            sdi_ready <= (state_nxt == IDLE) || (state_nxt == SHIFT);
            out_valid <= (state_nxt == HOLD);
            if (load_out) begin
                data_out      <= extract_data(corr_cw);
                syndrome      <= corr_syn;
                err_corrected <= |(corr_cw ^ sreg);
            end
            if (handshake) begin
                if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
                if ((syndrome != '0) && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hamming_rx_deser.sv
// Scoreboard bench for hamming_rx_deser: randomized encoded words with injected single-bit errors.
module tb_hamming_rx_deser;
    logic        clk;
    logic        rst;
    logic        sdi_valid;
    logic        sdi;
    logic        sdi_sof;
    logic        out_ready;
    logic        sdi_ready, out_valid, err_corrected, frame_err;
    logic [3:0]  data_out;
    logic [2:0]  syndrome;
    logic [15:0] word_cnt, err_cnt;
    logic        s_sdi_ready, s_out_valid, s_err_corrected, s_frame_err;
    logic [3:0]  s_data_out;
    logic [2:0]  s_syndrome;
    logic [1:0]  s_word_cnt, s_err_cnt;

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] s;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_words = 0;
    int   exp_errs = 0;

    hamming_rx_deser #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sdi_valid(sdi_valid), .sdi(sdi), .sdi_sof(sdi_sof),
        .sdi_ready(sdi_ready), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .syndrome(syndrome), .err_corrected(err_corrected),
        .word_cnt(word_cnt), .err_cnt(err_cnt), .frame_err(frame_err)
    );

    hamming_rx_deser #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .sdi_valid(sdi_valid), .sdi(sdi), .sdi_sof(sdi_sof),
        .sdi_ready(s_sdi_ready), .out_valid(s_out_valid), .out_ready(out_ready),
        .data_out(s_data_out), .syndrome(s_syndrome), .err_corrected(s_err_corrected),
        .word_cnt(s_word_cnt), .err_cnt(s_err_cnt), .frame_err(s_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Systematic encoder: data at positions 3,5,6,7; each parity makes its check group even.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
        c[0] = c[2] ^ c[4] ^ c[6];
        c[1] = c[2] ^ c[5] ^ c[6];
        c[3] = c[4] ^ c[5] ^ c[6];
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sdi_valid = 1'b0; sdi = 1'b0; sdi_sof = 1'b0;
        sb.delete();
        exp_words = 0;
        exp_errs = 0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!sdi_ready && k < 50) begin
            tick();
            k++;
        end
        check("sdi_ready_wait", sdi_ready, 1);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending words, required 0", sb.size());
        end
    endtask

    task automatic send_raw(input logic [6:0] cw, input logic [3:0] d, input logic [2:0] s);
        for (int i = 6; i >= 0; i--) begin
            sdi_valid = 1'b1;
            sdi       = cw[i];
            sdi_sof   = (i == 6);
            tick();
        end
        sdi_valid = 1'b0;
        sdi_sof   = 1'b0;
        sb.push_back('{d: d, s: s});
        exp_words++;
        if (s != 3'd0) exp_errs++;
    endtask

    task automatic send_word(input logic [3:0] d, input int pos);
        logic [6:0] cw;
        cw = encode(d);
        if (pos > 0) cw[pos-1] = ~cw[pos-1];
        wait_ready();
        send_raw(cw, d, 3'(pos));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got data %h syndrome %0d, required no word", data_out, syndrome);
            end else begin
                e = sb.pop_front();
                check("data_out", data_out, e.d);
                check("syndrome", syndrome, e.s);
                check("err_corrected", err_corrected, e.s != 3'd0);
            end
        end
    end

    initial begin
        logic [3:0] d;
        int         pos;
        out_ready = 1'b1;
        rst = 1'b0;
        sdi_valid = 1'b0; sdi = 1'b0; sdi_sof = 1'b0;
        tick();
        tick();
        check("rst_sdi_ready", sdi_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_syndrome", syndrome, 0);
        check("rst_err_corrected", err_corrected, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b1;
        tick();

        // Clean word and output latency relative to the 7th bit edge.
        send_raw(7'b1010101, 4'b1011, 3'd0);
        check("lat_decode_valid", out_valid, 0);
        check("lat_decode_ready", sdi_ready, 0);
        tick();
        check("lat_hold_valid", out_valid, 1);
        tick();
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", sdi_ready, 1);
        check("clean_word_cnt", word_cnt, 1);
        check("clean_err_cnt", err_cnt, 0);

        // Single-error sweep over all seven positions.
        for (int p = 1; p <= 7; p++) begin
            wait_ready();
            send_raw(7'b1010101 ^ (7'd1 << (p - 1)), 4'b1011, 3'(p));
            wait_drain();
        end
        check("sweep_word_cnt", word_cnt, exp_words);
        check("sweep_err_cnt", err_cnt, exp_errs);
        check("sweep_frame_err", frame_err, 0);

        // Backpressure with stray beats while the receiver is not ready.
        out_ready = 1'b0;
        d = 4'($urandom_range(0, 15));
        send_word(d, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_sdi_ready", sdi_ready, 0);
            check("bp_data_out", data_out, d);
            check("bp_syndrome", syndrome, 0);
            sdi_valid = 1'b1;
            sdi = 1'($urandom_range(0, 1));
            tick();
        end
        sdi_valid = 1'b0;
        check("bp_frame_err", frame_err, 1);
        check("bp_word_cnt_held", word_cnt, exp_words - 1);
        out_ready = 1'b1;
        tick();
        check("bp_word_cnt_once", word_cnt, exp_words);
        check("bp_valid_drop", out_valid, 0);
        tick();
        check("bp_word_cnt_stable", word_cnt, exp_words);

        // Sof after three bits restarts the frame.
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            sdi_valid = 1'b1;
            sdi = (i != 1);
            sdi_sof = (i == 0);
            tick();
        end
        check("partial_no_frame_err", frame_err, 0);
        send_raw(7'b1010101, 4'b1011, 3'd0);
        check("restart_frame_err", frame_err, 1);
        wait_drain();
        check("restart_word_cnt", word_cnt, 1);
        check("restart_err_cnt", err_cnt, 0);

        // Asynchronous reset while holding a word.
        out_ready = 1'b0;
        send_word(4'b1101, 3);
        tick();
        check("hold_before_rst", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_data_out", data_out, 0);
        check("arst_syndrome", syndrome, 0);
        check("arst_err_corrected", err_corrected, 0);
        check("arst_word_cnt", word_cnt, 0);
        check("arst_frame_err", frame_err, 0);
        check("arst_sdi_ready", sdi_ready, 1);
        sb.delete();
        exp_words = 0;
        exp_errs = 0;
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();

        // Five erroneous words saturate the 2-bit counters.
        for (int n = 0; n < 5; n++) begin
            send_word(4'($urandom_range(0, 15)), $urandom_range(1, 7));
            wait_drain();
        end
        check("sat_main_word_cnt", word_cnt, 5);
        check("sat_main_err_cnt", err_cnt, 5);
        check("sat_word_cnt", s_word_cnt, 3);
        check("sat_err_cnt", s_err_cnt, 3);

        // Randomized traffic with random consumer stalls.
        for (int n = 0; n < 30; n++) begin
            d = 4'($urandom_range(0, 15));
            pos = $urandom_range(0, 7);
            out_ready = 1'($urandom_range(0, 1));
            send_word(d, pos);
            repeat ($urandom_range(0, 4)) tick();
            out_ready = 1'b1;
            wait_drain();
        end
        check("rand_word_cnt", word_cnt, exp_words);
        check("rand_err_cnt", err_cnt, exp_errs);
        check("rand_sat_word_cnt", s_word_cnt, (exp_words > 3) ? 3 : exp_words);
        check("rand_sat_err_cnt", s_err_cnt, (exp_errs > 3) ? 3 : exp_errs);
        check("rand_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
